y86_run_ctrl: RTL and testbench
===============================

Name: y86_run_ctrl

Overview:
Run/debug controller that sequences the single-cycle y86 CPU (y86_cpu) from a host command port. It loads instruction memory byte-wise and releases the CPU into run or single-step. It stops the CPU on halt, fault, PC breakpoint or watchdog expiry, and counts executed cycles. It replaces hierarchical memory pokes in benches and is the control point for FPGA bring-up.

Parameters:
ADDR_W, 10, instruction-memory byte address width (1024 bytes)
CNT_W, 32, executed-cycle counter width
MAX_CYCLES, 0, watchdog limit on executed cycles; 0 disables

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset; one clock, asynchronous assert, active-low
cmd_valid_i  in  1  host command valid
cmd_ready_o  out  1  controller accepts command this cycle
cmd_op_i  in  3  0 NOP, 1 WRITE, 2 RUN, 3 STEP, 4 STOP, 5 SET_BP, 6 CLR_BP, 7 RESET_CPU
cmd_addr_i  in  ADDR_W  byte address (WRITE) or breakpoint PC (SET_BP)
cmd_data_i  in  8  write byte (WRITE)
cpu_pc_i  in  64  PC of instruction executing this cycle
cpu_stat_i  in  3  CPU status: 1 AOK, 2 HLT, 3 ADR, 4 INS
cpu_en_o  out  1  CPU clock enable; CPU state commits only when high
cpu_rst_n_o  out  1  CPU synchronous reset, active-low
imem_we_o  out  1  instruction-memory byte write strobe
imem_addr_o  out  ADDR_W  write address
imem_wdata_o  out  8  write data
state_o  out  3  0 IDLE, 1 RUN, 2 STEP, 3 PAUSED, 4 HALTED, 5 FAULT, 6 TIMEOUT, 7 RSTCPU
cycle_cnt_o  out  CNT_W  number of cycles with cpu_en_o=1 since last CPU reset
bp_hit_o  out  1  one-cycle pulse on breakpoint stop
err_o  out  1  one-cycle pulse on an illegal command

Behaviour:
- Reset values: state IDLE; cpu_en_o=0; cpu_rst_n_o=0 during reset, 1 after; imem_we_o=0; imem_addr_o=0; imem_wdata_o=0; cycle_cnt_o=0; breakpoint invalid; bp_hit_o=0; err_o=0. Reset asserted mid-run aborts immediately; the CPU sees cpu_en_o=0 at once.
- Handshake: a command is accepted when cmd_valid_i && cmd_ready_o. cmd_ready_o=1 in every state except RSTCPU. One command is accepted per cycle.
- WRITE: legal in IDLE, PAUSED, HALTED, FAULT and TIMEOUT. It is registered: imem_we_o/addr/wdata are driven for exactly one cycle, the cycle after acceptance. WRITE in RUN or STEP is dropped, err_o pulses, and there is no strobe.
- RUN: legal from IDLE or PAUSED; next state RUN. The first RUN cycle ignores the breakpoint (skip flag), so a run can resume from a breakpoint PC. From HALTED, FAULT or TIMEOUT it is illegal: err_o pulses.
- STEP: same legality as RUN; next state STEP. cpu_en_o=1 for exactly one cycle and the breakpoint is ignored. Next state is PAUSED, unless the status rule below applies.
- STOP: RUN to PAUSED; a no-op in other states.
- SET_BP / CLR_BP: legal in any state; take effect the next cycle.
- RESET_CPU: any state goes to RSTCPU for one cycle. During that cycle cpu_rst_n_o=0 and cpu_en_o=0; cycle_cnt_o clears to 0. The breakpoint and memory contents are kept. Next state is IDLE.
- cpu_en_o is combinational:
  - RUN: 1, except 0 when bp_valid && cpu_pc_i==bp_addr (zero-extended) && !skip.
  - STEP: 1.
  - All other states: 0.
- Breakpoint hit in RUN: cpu_en_o=0 that cycle and the instruction is not executed. Next state is PAUSED with cpu_pc_i held at the breakpoint; bp_hit_o pulses next cycle.
- Status, checked whenever cpu_en_o=1:
  - HLT: the halt commits; next state HALTED.
  - ADR or INS: next state FAULT.
  - Any value outside 1..4: treated as INS.
- Precedence within one cycle: RESET_CPU > status stop > watchdog > STOP command > stay.
- cycle_cnt_o increments on every cycle with cpu_en_o=1 and saturates at all-ones.
- Watchdog (MAX_CYCLES>0): on the cycle where the counter reaches MAX_CYCLES with cpu_en_o=1, next state is TIMEOUT unless a status stop applies the same cycle.
- Commands that arrive while a stop condition fires are still evaluated against the current state.

Decomposition:
- Shared package y86_pkg holds:
  - stat codes (STAT_AOK=1, STAT_HLT=2, STAT_ADR=3, STAT_INS=4);
  - command opcodes;
  - the run-state enum.
- One sub-module, y86_cycle_wdog: the saturating counter plus watchdog compare, with inputs en, clr and outputs cnt, expired.
- The FSM, breakpoint register and memory write port stay in y86_run_ctrl.

Test Plan:
- Load program: nop @0; irmovq $200,%rsp @1; irmovq $10,%rax @11; irmovq $10,%rbx @21; subq @31; irmovq $5,%rax @33; subq @43; halt @45. Load via 46 WRITEs, then RUN. Required: state HALTED, cycle_cnt_o=8, rax=-5, rbx=10, and exactly 46 imem_we_o pulses.
- Same program, SET_BP 31, RUN. Required: PAUSED with cpu_pc_i=31, cycle_cnt_o=4, one bp_hit_o pulse. Then STEP: PAUSED, cpu_pc_i=33, cycle_cnt_o=5. Then RUN: HALTED, cycle_cnt_o=8.
- MAX_CYCLES=16, program "jmp 0" at address 0, RUN. Required: TIMEOUT with cycle_cnt_o=16 and cpu_en_o=0 thereafter.
- Byte 0xF0 at address 0, RUN. Required: the CPU reports INS; state FAULT after 1 cycle; a following RUN pulses err_o with the state unchanged.
- WRITE during RUN. Required: err_o pulse and no imem_we_o. RESET_CPU mid-run: one cycle of cpu_rst_n_o=0, then IDLE with cycle_cnt_o=0 and the breakpoint retained.
- Assert rst_n_i mid-RUN. Required: cpu_en_o falls without waiting for a clock edge; after release state is IDLE and all outputs are at reset values.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared CPU status codes, host command opcodes and run-controller states.
package y86_pkg;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  typedef enum logic [2:0] {
    OP_NOP, OP_WRITE, OP_RUN, OP_STEP, OP_STOP, OP_SET_BP, OP_CLR_BP, OP_RESET_CPU
  } cmd_op_e;
  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_STEP, S_PAUSED, S_HALTED, S_FAULT, S_TIMEOUT, S_RSTCPU
  } run_state_e;
endpackage

// File: rtl/y86_cycle_wdog.sv
// y86_cycle_wdog: saturating executed-cycle counter with a watchdog compare.
module y86_cycle_wdog #(
  parameter int CNT_W = 32,
  parameter int unsigned MAX_CYCLES = 0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             expired
);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !(&cnt)) cnt <= cnt + 1'b1;
  // fires on the enabled cycle that brings the count up to the limit
  assign expired = (MAX_CYCLES != 0) && en && (cnt == CNT_W'(MAX_CYCLES - 1));
endmodule

// File: rtl/y86_run_ctrl.sv
// y86_run_ctrl: host-driven run/step/breakpoint controller and imem loader for the y86 CPU.
module y86_run_ctrl
  import y86_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W = 32,
  parameter int unsigned MAX_CYCLES = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [7:0]        cmd_data_i,
  input  logic [63:0]       cpu_pc_i,
  input  logic [2:0]        cpu_stat_i,
  output logic              cpu_en_o,
  output logic              cpu_rst_n_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [7:0]        imem_wdata_o,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic              bp_hit_o,
  output logic              err_o
);
  run_state_e state, state_nx;
  cmd_op_e op;
  logic acc, running, legal_go, wr_ok, bp_stop, halt_stop, fault_stop, wd_exp;
  logic skip, bp_valid;
  logic [ADDR_W-1:0] bp_addr;

  assign op = cmd_op_e'(cmd_op_i);
  assign acc = cmd_valid_i && cmd_ready_o;
  assign running = state == S_RUN || state == S_STEP;
  assign legal_go = state == S_IDLE || state == S_PAUSED;
  assign wr_ok = acc && op == OP_WRITE && !running;
  // skip masks the breakpoint on the first run cycle so a paused run can resume
  assign bp_stop = state == S_RUN && bp_valid && !skip && cpu_pc_i == 64'(bp_addr);
  assign halt_stop = cpu_en_o && cpu_stat_i == STAT_HLT;
  assign fault_stop = cpu_en_o && cpu_stat_i != STAT_AOK && cpu_stat_i != STAT_HLT;

  y86_cycle_wdog #(.CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)) u_wdog (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en      (cpu_en_o),
    .clr     (acc && op == OP_RESET_CPU),
    .cnt     (cycle_cnt_o),
    .expired (wd_exp)
  );

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= S_IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    if (acc && op == OP_RESET_CPU) state_nx = S_RSTCPU;
    else if (state == S_RSTCPU) state_nx = S_IDLE;
    else if (halt_stop) state_nx = S_HALTED;
    else if (fault_stop) state_nx = S_FAULT;
    else if (wd_exp) state_nx = S_TIMEOUT;
    else if (state == S_STEP || bp_stop || (state == S_RUN && acc && op == OP_STOP)) state_nx = S_PAUSED;
    else if (acc && legal_go && (op == OP_RUN || op == OP_STEP)) state_nx = op == OP_RUN ? S_RUN : S_STEP;
  end

  always_comb begin
    cmd_ready_o = state != S_RSTCPU;
    cpu_en_o = state == S_STEP || (state == S_RUN && !bp_stop);
    cpu_rst_n_o = rst_n_i && state != S_RSTCPU;
    state_o = state;
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      skip <= 1'b0;
      bp_valid <= 1'b0;
      bp_addr <= '0;
      bp_hit_o <= 1'b0;
      err_o <= 1'b0;
      imem_we_o <= 1'b0;
      imem_addr_o <= '0;
      imem_wdata_o <= '0;
    end else begin
      skip <= acc && op == OP_RUN && legal_go;
      bp_hit_o <= bp_stop && state_nx == S_PAUSED;
      err_o <= acc && ((op == OP_WRITE && running) || ((op == OP_RUN || op == OP_STEP) && !legal_go));
      imem_we_o <= wr_ok;
      if (wr_ok) begin
        imem_addr_o <= cmd_addr_i;
        imem_wdata_o <= cmd_data_i;
      end
      if (acc && op == OP_SET_BP) begin
        bp_valid <= 1'b1;
        bp_addr <= cmd_addr_i;
      end else if (acc && op == OP_CLR_BP) bp_valid <= 1'b0;
    end
endmodule

// File: tb/tb_y86_run_ctrl.sv
// tb_y86_run_ctrl: directed bench driving the controller against a tiny behavioural y86 core.
module tb_y86_run_ctrl;
  import y86_pkg::*;
  localparam int ADDR_W = 10;
  localparam int CNT_W = 32;

  logic clk_i = 1'b0, rst_n_i = 1'b1, cmd_valid_i = 1'b0;
  logic [2:0] cmd_op_i = '0;
  logic [ADDR_W-1:0] cmd_addr_i = '0;
  logic [7:0] cmd_data_i = '0;
  logic [63:0] cpu_pc_i;
  logic [2:0] cpu_stat_i;
  logic cmd_ready_o, cpu_en_o, cpu_rst_n_o, imem_we_o, bp_hit_o, err_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [7:0] imem_wdata_o;
  logic [2:0] state_o;
  logic [CNT_W-1:0] cycle_cnt_o;

  int total = 0, bad = 0, we_cnt = 0, bp_cnt = 0, we_before = 0;
  logic [17:0] wq[$];

  always #5 clk_i = ~clk_i;

  y86_run_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .cpu_pc_i(cpu_pc_i), .cpu_stat_i(cpu_stat_i), .cpu_en_o(cpu_en_o), .cpu_rst_n_o(cpu_rst_n_o),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
    .state_o(state_o), .cycle_cnt_o(cycle_cnt_o), .bp_hit_o(bp_hit_o), .err_o(err_o)
  );

  // behavioural core: nop, irmovq, subq, jmp, halt; anything else reports INS
  logic [7:0] mem [0:1023];
  logic [63:0] regs [0:15];
  logic [63:0] pc;
  logic [7:0] b0, b1;

  function automatic logic [63:0] rd8(input logic [63:0] a);
    for (int k = 0; k < 8; k++) rd8[8*k +: 8] = mem[10'(a + 64'(k))];
  endfunction

  assign b0 = mem[pc[9:0]];
  assign b1 = mem[10'(pc + 64'd1)];
  assign cpu_pc_i = pc;
  assign cpu_stat_i = b0 == 8'h00 ? STAT_HLT :
                      (b0 == 8'h10 || b0 == 8'h30 || b0 == 8'h61 || b0 == 8'h70) ? STAT_AOK : STAT_INS;

  always @(posedge clk_i) begin
    if (imem_we_o) mem[imem_addr_o] <= imem_wdata_o;
    if (!cpu_rst_n_o) begin
      pc <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (cpu_en_o) begin
      case (b0)
        8'h10: pc <= pc + 64'd1;
        8'h30: begin regs[b1[3:0]] <= rd8(pc + 64'd2); pc <= pc + 64'd10; end
        8'h61: begin regs[b1[3:0]] <= regs[b1[3:0]] - regs[b1[7:4]]; pc <= pc + 64'd2; end
        8'h70: pc <= rd8(pc + 64'd1);
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every strobe must match the oldest accepted legal WRITE
  always @(negedge clk_i) begin
    if (imem_we_o) begin
      we_cnt++;
      chk("wr_expected", 64'(wq.size() != 0), 64'd1);
      if (wq.size() != 0) chk("imem_wr", 64'({imem_addr_o, imem_wdata_o}), 64'(wq.pop_front()));
    end
    if (bp_hit_o) bp_cnt++;
  end

  task automatic send(input logic [2:0] op, input logic [9:0] a = '0, input logic [7:0] d = '0);
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_addr_i = a; cmd_data_i = d;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0; cmd_op_i = '0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    wq.push_back({a, d});
    send(OP_WRITE, a, d);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int max);
    for (int i = 0; i < max; i++) begin
      if (state_o == s) break;
      @(posedge clk_i); #1;
    end
    chk(tag, 64'(state_o), 64'(s));
  endtask

  logic [7:0] prog [46] = '{
    8'h10,
    8'h30, 8'hF4, 8'hC8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h30, 8'hF0, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h30, 8'hF3, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h61, 8'h30,
    8'h30, 8'hF0, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h61, 8'h30,
    8'h00};

  initial begin
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_cpu_rst_n", 64'(cpu_rst_n_o), 64'd0);
    chk("rst_en", 64'(cpu_en_o), 64'd0);
    cyc(2);
    @(negedge clk_i) rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_state", 64'(state_o), 64'(S_IDLE));
    chk("rst_cpu_rst_n_after", 64'(cpu_rst_n_o), 64'd1);
    chk("rst_ready", 64'(cmd_ready_o), 64'd1);
    chk("rst_cnt", 64'(cycle_cnt_o), 64'd0);

    // full program to halt
    for (int i = 0; i < 46; i++) wr(10'(i), prog[i]);
    send(OP_RUN);
    wait_state("prog_halted", S_HALTED, 50);
    chk("prog_cnt", 64'(cycle_cnt_o), 64'd8);
    chk("prog_rax", regs[0], 64'hFFFF_FFFF_FFFF_FFFB);
    chk("prog_rbx", regs[3], 64'd10);
    chk("prog_we_pulses", 64'(we_cnt), 64'd46);
    chk("prog_en_off", 64'(cpu_en_o), 64'd0);

    // breakpoint, step, resume
    send(OP_RESET_CPU);
    cyc(1);
    bp_cnt = 0;
    send(OP_SET_BP, 10'd31);
    send(OP_RUN);
    wait_state("bp_paused", S_PAUSED, 50);
    chk("bp_pc", cpu_pc_i, 64'd31);
    chk("bp_cnt", 64'(cycle_cnt_o), 64'd4);
    cyc(2);
    chk("bp_pulses", 64'(bp_cnt), 64'd1);
    send(OP_STEP);
    wait_state("step_paused", S_PAUSED, 5);
    chk("step_pc", cpu_pc_i, 64'd33);
    chk("step_cnt", 64'(cycle_cnt_o), 64'd5);
    send(OP_RUN);
    wait_state("resume_halted", S_HALTED, 50);
    chk("resume_cnt", 64'(cycle_cnt_o), 64'd8);

    // watchdog on an endless jump
    send(OP_RESET_CPU);
    cyc(1);
    send(OP_CLR_BP);
    wr(10'd0, 8'h70);
    for (int i = 1; i < 9; i++) wr(10'(i), 8'h00);
    send(OP_RUN);
    wait_state("wd_timeout", S_TIMEOUT, 40);
    chk("wd_cnt", 64'(cycle_cnt_o), 64'd16);
    cyc(3);
    chk("wd_en_off", 64'(cpu_en_o), 64'd0);
    chk("wd_cnt_hold", 64'(cycle_cnt_o), 64'd16);

    // illegal opcode faults after one cycle; RUN from FAULT is an error
    send(OP_RESET_CPU);
    cyc(1);
    wr(10'd0, 8'hF0);
    send(OP_RUN);
    chk("ins_stat", 64'(cpu_stat_i), 64'(STAT_INS));
    cyc(1);
    chk("ins_fault", 64'(state_o), 64'(S_FAULT));
    chk("ins_cnt", 64'(cycle_cnt_o), 64'd1);
    send(OP_RUN);
    chk("fault_run_err", 64'(err_o), 64'd1);
    chk("fault_run_state", 64'(state_o), 64'(S_FAULT));
    cyc(1);
    chk("fault_err_pulse", 64'(err_o), 64'd0);

    // WRITE while running is rejected; RESET_CPU mid-run
    send(OP_RESET_CPU);
    cyc(1);
    wr(10'd0, 8'h70);
    send(OP_RUN);
    cyc(1);
    we_before = we_cnt;
    send(OP_WRITE, 10'd100, 8'h55);
    chk("run_wr_err", 64'(err_o), 64'd1);
    cyc(2);
    chk("run_wr_no_we", 64'(we_cnt), 64'(we_before));
    chk("run_wr_state", 64'(state_o), 64'(S_RUN));
    send(OP_RESET_CPU);
    chk("rstcpu_state", 64'(state_o), 64'(S_RSTCPU));
    chk("rstcpu_rst_n", 64'(cpu_rst_n_o), 64'd0);
    chk("rstcpu_en", 64'(cpu_en_o), 64'd0);
    chk("rstcpu_ready", 64'(cmd_ready_o), 64'd0);
    chk("rstcpu_cnt", 64'(cycle_cnt_o), 64'd0);
    cyc(1);
    chk("rstcpu_idle", 64'(state_o), 64'(S_IDLE));
    chk("rstcpu_rst_n_rel", 64'(cpu_rst_n_o), 64'd1);

    // breakpoint survives RESET_CPU
    bp_cnt = 0;
    send(OP_SET_BP, 10'd0);
    send(OP_RESET_CPU);
    cyc(1);
    send(OP_RUN);
    wait_state("keep_bp_paused", S_PAUSED, 10);
    chk("keep_bp_cnt", 64'(cycle_cnt_o), 64'd1);
    cyc(1);
    chk("keep_bp_pulse", 64'(bp_cnt), 64'd1);

    // asynchronous reset mid-run
    send(OP_CLR_BP);
    send(OP_RUN);
    cyc(2);
    chk("arst_running", 64'(cpu_en_o), 64'd1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_en_now", 64'(cpu_en_o), 64'd0);
    chk("arst_state_now", 64'(state_o), 64'(S_IDLE));
    chk("arst_cpu_rst_n", 64'(cpu_rst_n_o), 64'd0);
    cyc(1);
    @(negedge clk_i) rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("arst_state", 64'(state_o), 64'(S_IDLE));
    chk("arst_en", 64'(cpu_en_o), 64'd0);
    chk("arst_rst_n", 64'(cpu_rst_n_o), 64'd1);
    chk("arst_imem", 64'({imem_we_o, imem_addr_o, imem_wdata_o}), 64'd0);
    chk("arst_cnt", 64'(cycle_cnt_o), 64'd0);
    chk("arst_pulses", 64'({bp_hit_o, err_o}), 64'd0);
    chk("wq_drained", 64'(wq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
